// File: rtl/pipe_commit_tracker_if.sv
// pipe_commit_tracker_if: issue/stall/end-select inputs and tracker qualifier outputs
interface pipe_commit_tracker_if #(
  parameter int STAGES = 4,
  parameter int PIPES  = 2,
  parameter int CNT_W  = 8
);
  logic                    issue_i;
  logic [PIPES-1:0]        pipe_en_i;
  logic [PIPES*STAGES-1:0] stall_i;
  logic [PIPES-1:0]        end_sel_i;
  logic                    start_o;
  logic                    started_o;
  logic [CNT_W-1:0]        cycle_cnt_o;
  logic [PIPES*STAGES-1:0] stage_tok_o;
  logic [PIPES-1:0]        commit_o;
  logic                    edcond_o;
  logic                    iend_o;
  logic                    ended_o;
  logic                    ended2_o;
  logic                    timeout_o;
  logic [CNT_W-1:0]        commit_lat_o;
  modport master (
    output issue_i, pipe_en_i, stall_i, end_sel_i,
    input  start_o, started_o, cycle_cnt_o, stage_tok_o, commit_o, edcond_o,
           iend_o, ended_o, ended2_o, timeout_o, commit_lat_o
  );
  modport slave (
    input  issue_i, pipe_en_i, stall_i, end_sel_i,
    output start_o, started_o, cycle_cnt_o, stage_tok_o, commit_o, edcond_o,
           iend_o, ended_o, ended2_o, timeout_o, commit_lat_o
  );
endinterface

// File: rtl/pipe_commit_tracker.sv
// pipe_commit_tracker: follows one issued token through stall-gated pipes and derives commit/end qualifiers
module pipe_commit_tracker #(
  parameter int STAGES     = 4,
  parameter int PIPES      = 2,
  parameter int CNT_W      = 8,
  parameter int MAX_CYCLES = 132,
  parameter int END_BOUND  = 50
) (
  input logic                  clk,
  input logic                  rst,
  pipe_commit_tracker_if.slave bus
);
  localparam int N = PIPES * STAGES;
  // Slot k=0 of each pipe holds the S1 hold bit; slots k>=1 are the stage token registers.
  logic [N-1:0]     st_q, st_d, tok, nxt;
  logic [PIPES-1:0] commit_q, commit_d;
  logic             start_q, start_d, started_q, started_d;
  logic             ended_q, ended_d, ended2_q, ended2_d, timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_q, lat_d;
  logic             edcond, iend;
  // Token occupancy and movement: a stage only accepts its predecessor's token when not stalled.
  always_comb begin
    tok      = st_q;
    st_d     = '0;
    commit_d = '0;
    for (int p = 0; p < PIPES; p++)
      tok[p*STAGES] = (start_q & bus.pipe_en_i[p]) | st_q[p*STAGES];
    nxt = tok & ~bus.stall_i;
    for (int p = 0; p < PIPES; p++) begin
      st_d[p*STAGES] = tok[p*STAGES] & bus.stall_i[p*STAGES];
      for (int k = 1; k < STAGES; k++)
        st_d[p*STAGES+k] = bus.stall_i[p*STAGES+k] ? st_q[p*STAGES+k] : nxt[p*STAGES+k-1];
      commit_d[p] = nxt[p*STAGES+STAGES-1];
    end
  end
  // Start/end qualifiers, saturating cycle counter and latency capture.
  always_comb begin
    edcond    = started_q & |(commit_q & bus.end_sel_i);
    iend      = edcond & ~ended_q & ~timeout_q & (cnt_q <= CNT_W'(END_BOUND));
    start_d   = bus.issue_i & ~start_q & ~started_q;
    started_d = started_q | start_q;
    cnt_d     = ((start_q | started_q) && cnt_q < CNT_W'(MAX_CYCLES)) ? cnt_q + CNT_W'(1) : cnt_q;
    ended_d   = ended_q | iend;
    lat_d     = iend ? cnt_q : lat_q;
    ended2_d  = ended2_q | (ended_q & edcond);
    timeout_d = timeout_q | (started_q & ~ended_q & (cnt_q > CNT_W'(END_BOUND)));
  end
  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '0;
      commit_q  <= '0;
      start_q   <= 1'b0;
      started_q <= 1'b0;
      ended_q   <= 1'b0;
      ended2_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      lat_q     <= '0;
    end else begin
      st_q      <= st_d;
      commit_q  <= commit_d;
      start_q   <= start_d;
      started_q <= started_d;
      ended_q   <= ended_d;
      ended2_q  <= ended2_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
    end
  end
  assign bus.start_o      = start_q;
  assign bus.started_o    = started_q;
  assign bus.cycle_cnt_o  = cnt_q;
  assign bus.stage_tok_o  = tok;
  assign bus.commit_o     = commit_q;
  assign bus.edcond_o     = edcond;
  assign bus.iend_o       = iend;
  assign bus.ended_o      = ended_q;
  assign bus.ended2_o     = ended2_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.commit_lat_o = lat_q;
endmodule

// File: tb/tb_pipe_commit_tracker.sv
// tb_pipe_commit_tracker: directed and random checks against a token-position reference model
module tb_pipe_commit_tracker;
  localparam int S = 4, P = 2, W = 8, MAXC = 132, EB = 50;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pipe_commit_tracker_if #(.STAGES(S), .PIPES(P), .CNT_W(W)) bus();
  pipe_commit_tracker #(.STAGES(S), .PIPES(P), .CNT_W(W), .MAX_CYCLES(MAXC), .END_BOUND(EB))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  logic m_start, m_started, m_ended, m_ended2, m_timeout;
  logic [P-1:0] m_commit;
  int m_cnt, m_lat;
  int pos [P];
  int tc, f_iend, f_end2, f_to;
  int f_com [P];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    m_start = 0; m_started = 0; m_ended = 0; m_ended2 = 0; m_timeout = 0;
    m_commit = '0; m_cnt = 0; m_lat = 0;
    for (int p = 0; p < P; p++) pos[p] = -1;
  endtask
  task automatic clr_marks();
    tc = 0; f_iend = -1; f_end2 = -1; f_to = -1;
    for (int p = 0; p < P; p++) f_com[p] = -1;
  endtask
  task automatic cyc();
    int cur [P];
    int np [P];
    logic [P*S-1:0] et;
    logic [P-1:0] nc;
    logic ed, ie, n_start, n_started, n_ended, n_end2, n_to;
    int n_cnt, n_lat;
    #1;
    et = '0;
    for (int p = 0; p < P; p++) begin
      cur[p] = (m_start && bus.pipe_en_i[p]) ? 0 : pos[p];
      if (cur[p] >= 0) et[p*S+cur[p]] = 1'b1;
    end
    ed = m_started && |(m_commit & bus.end_sel_i);
    ie = ed && !m_ended && !m_timeout && m_cnt <= EB;
    chk("start", 32'(bus.start_o), 32'(m_start));
    chk("started", 32'(bus.started_o), 32'(m_started));
    chk("cnt", 32'(bus.cycle_cnt_o), 32'(m_cnt));
    chk("stage_tok", 32'(bus.stage_tok_o), 32'(et));
    chk("commit", 32'(bus.commit_o), 32'(m_commit));
    chk("edcond", 32'(bus.edcond_o), 32'(ed));
    chk("iend", 32'(bus.iend_o), 32'(ie));
    chk("ended", 32'(bus.ended_o), 32'(m_ended));
    chk("ended2", 32'(bus.ended2_o), 32'(m_ended2));
    chk("timeout", 32'(bus.timeout_o), 32'(m_timeout));
    chk("lat", 32'(bus.commit_lat_o), 32'(m_lat));
    if (bus.iend_o && f_iend < 0) f_iend = tc;
    if (bus.ended2_o && f_end2 < 0) f_end2 = tc;
    if (bus.timeout_o && f_to < 0) f_to = tc;
    for (int p = 0; p < P; p++) if (bus.commit_o[p] && f_com[p] < 0) f_com[p] = tc;
    nc = '0;
    for (int p = 0; p < P; p++) begin
      np[p] = cur[p];
      if (cur[p] >= 0 && !bus.stall_i[p*S+cur[p]]) begin
        if (cur[p] == S-1) begin
          nc[p] = 1'b1;
          np[p] = -1;
        end else np[p] = bus.stall_i[p*S+cur[p]+1] ? -1 : cur[p] + 1;
      end
    end
    n_start = bus.issue_i && !m_start && !m_started;
    n_started = m_started || m_start;
    n_cnt = ((m_start || m_started) && m_cnt < MAXC) ? m_cnt + 1 : m_cnt;
    n_ended = m_ended || ie;
    n_lat = ie ? m_cnt : m_lat;
    n_end2 = m_ended2 || (m_ended && ed);
    n_to = m_timeout || (m_started && !m_ended && m_cnt > EB);
    @(posedge clk);
    if (rst) model_clear();
    else begin
      m_start = n_start; m_started = n_started; m_cnt = n_cnt; m_ended = n_ended;
      m_lat = n_lat; m_ended2 = n_end2; m_timeout = n_to; m_commit = nc;
      for (int p = 0; p < P; p++) pos[p] = np[p];
    end
    tc++;
    #1;
  endtask
  task automatic run(input logic [P-1:0] en, input logic [P-1:0] sel, input int sbit,
                     input int sfrom, input int sto, input int n);
    rst = 1; bus.issue_i = 0; bus.stall_i = '0; bus.pipe_en_i = en; bus.end_sel_i = sel;
    cyc();
    rst = 0;
    clr_marks();
    for (int c = 0; c < n; c++) begin
      bus.issue_i = (c == 0);
      bus.stall_i = '0;
      if (c >= sfrom && c <= sto) bus.stall_i[sbit] = 1'b1;
      cyc();
    end
  endtask
  initial begin
    rst = 1; bus.issue_i = 0; bus.stall_i = '0; bus.pipe_en_i = '0; bus.end_sel_i = '0;
    @(posedge clk); #1;
    model_clear();
    clr_marks();
    chk("reset_cnt", 32'(bus.cycle_cnt_o), 0);
    chk("reset_flags", 32'({bus.start_o, bus.started_o, bus.ended_o, bus.ended2_o, bus.timeout_o}), 0);
    chk("reset_tok", 32'(bus.stage_tok_o), 0);
    run(2'b01, 2'b01, 0, -1, -1, 10);
    chk("s1_commit0_cyc", f_com[0], 5);
    chk("s1_iend_cyc", f_iend, 5);
    chk("s1_lat", 32'(bus.commit_lat_o), 4);
    chk("s1_ended", 32'(bus.ended_o), 1);
    run(2'b01, 2'b01, 2, 3, 5, 12);
    chk("s2_commit0_cyc", f_com[0], 8);
    chk("s2_lat", 32'(bus.commit_lat_o), 7);
    run(2'b11, 2'b10, 4, 1, 2, 12);
    chk("s3_commit0_cyc", f_com[0], 5);
    chk("s3_commit1_cyc", f_com[1], 7);
    chk("s3_iend_cyc", f_iend, 7);
    chk("s3_lat", 32'(bus.commit_lat_o), 6);
    run(2'b11, 2'b11, 5, 2, 4, 12);
    chk("s4_iend_cyc", f_iend, 5);
    chk("s4_commit1_cyc", f_com[1], 8);
    chk("s4_ended2_cyc", f_end2, 9);
    run(2'b01, 2'b01, 1, 2, 70, 140);
    chk("s5_timeout_cyc", f_to, 53);
    chk("s5_commit0_cyc", f_com[0], 74);
    chk("s5_no_iend", f_iend, -1);
    chk("s5_ended", 32'(bus.ended_o), 0);
    chk("s5_cnt_sat", 32'(bus.cycle_cnt_o), 132);
    run(2'b01, 2'b01, 1, 2, 47, 60);
    chk("bound_iend_cyc", f_iend, 51);
    chk("bound_lat", 32'(bus.commit_lat_o), 50);
    chk("bound_timeout", 32'(bus.timeout_o), 0);
    run(2'b01, 2'b01, 1, 2, 48, 60);
    chk("over_no_iend", f_iend, -1);
    chk("over_ended", 32'(bus.ended_o), 0);
    chk("over_timeout", 32'(bus.timeout_o), 1);
    run(2'b01, 2'b01, 0, -1, -1, 3);
    chk("rst_tok_s3", 32'(bus.stage_tok_o), 32'h4);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_all_zero", 32'({bus.start_o, bus.started_o, bus.stage_tok_o, bus.commit_o, bus.ended_o,
                             bus.ended2_o, bus.timeout_o, bus.iend_o, bus.edcond_o}), 0);
    chk("rst_cnt_zero", 32'({bus.cycle_cnt_o, bus.commit_lat_o}), 0);
    cyc();
    for (int c = 5; c < 14; c++) begin
      bus.issue_i = (c == 5);
      cyc();
    end
    chk("rst_reissue_commit", f_com[0], 10);
    chk("rst_reissue_lat", 32'(bus.commit_lat_o), 4);
    for (int r = 0; r < 6; r++) begin
      rst = 1; cyc(); rst = 0;
      for (int c = 0; c < 60; c++) begin
        bus.issue_i = ($urandom_range(0, 3) == 0);
        bus.pipe_en_i = P'($urandom);
        bus.end_sel_i = P'($urandom);
        bus.stall_i = (P*S)'($urandom & $urandom & $urandom);
        rst = ($urandom_range(0, 49) == 0);
        cyc();
      end
      rst = 0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
